// File: rtl/posit_mult_arbiter.sv
// -----------------------------------------------------------------------------
// posit_mult_arbiter
//
// Shares one pipelined posit multiplier between NREQ requesters. Requesters
// present operand pairs with a valid bit; a rotating-priority arbiter grants
// at most one of them per cycle. The granted operands are registered and
// issued to the multiplier with a one-cycle start strobe. A tag pipeline that
// is LAT stages deep follows each issued operation. It remembers which
// requester owns the result, and it catches multiplier completion strobes that
// do not line up with an issued operation.
//
// Parameters
//   NREQ : number of requesters (2..8)
//   LAT  : multiplier latency, cycles from o_mul_start high to i_mul_done high
//
// Ports
//   i_clk         : clock, rising edge
//   i_rst_n       : asynchronous active-low reset
//   i_en          : grant enable; in-flight operations complete regardless
//   i_req_valid   : [NREQ]      per-requester operand valid
//   i_req_in1     : [32*NREQ]   operand A, requester i at [32i+31:32i]
//   i_req_in2     : [32*NREQ]   operand B, same packing
//   o_req_ready   : [NREQ]      combinational one-hot-or-zero grant
//   o_mul_start   : issue strobe to the multiplier
//   o_mul_in1/2   : [32]        operands to the multiplier (held between issues)
//   i_mul_result  : [32]        multiplier product
//   i_mul_inf     : multiplier infinity/NaR flag
//   i_mul_zero    : multiplier zero flag
//   i_mul_done    : multiplier completion strobe
//   o_res_valid   : [NREQ]      one-hot-or-zero result strobe
//   o_res_data    : [32]        registered product (held between results)
//   o_res_inf     : registered infinity flag
//   o_res_zero    : registered zero flag
//   o_busy        : an operation has been issued and its result is not yet back
//   o_err         : sticky; a completion strobe did not match the tag pipeline
// -----------------------------------------------------------------------------
module posit_mult_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [32*NREQ-1:0]   i_req_in1,
    input  logic [32*NREQ-1:0]   i_req_in2,
    output logic [NREQ-1:0]      o_req_ready,
    output logic                 o_mul_start,
    output logic [31:0]          o_mul_in1,
    output logic [31:0]          o_mul_in2,
    input  logic [31:0]          i_mul_result,
    input  logic                 i_mul_inf,
    input  logic                 i_mul_zero,
    input  logic                 i_mul_done,
    output logic [NREQ-1:0]      o_res_valid,
    output logic [31:0]          o_res_data,
    output logic                 o_res_inf,
    output logic                 o_res_zero,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int IDW = $clog2(NREQ);

    // ------------------------------------------------------------------
    // Operand unpacking
    // ------------------------------------------------------------------
    logic [31:0] w_op1 [NREQ];
    logic [31:0] w_op2 [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_op1[gi] = i_req_in1[32*gi +: 32];
            assign w_op2[gi] = i_req_in2[32*gi +: 32];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Rotating-priority grant
    // The search starts one past the last granted requester and wraps. So a
    // requester that keeps its valid high waits until every other active
    // requester has had a turn.
    // ------------------------------------------------------------------
    logic [IDW-1:0]  r_last_grant;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_grant_id;
    logic            w_grant_any;
    logic [IDW:0]    w_sum;
    logic [IDW-1:0]  w_idx;

    always_comb begin
        w_grant     = '0;
        w_grant_id  = '0;
        w_grant_any = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            // The sum is one bit wider than an id, so last + k cannot
            // overflow before the wrap is applied.
            w_sum = {1'b0, r_last_grant} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end
            w_idx = w_sum[IDW-1:0];
            if (!w_grant_any && i_req_valid[w_idx]) begin
                w_grant_any = 1'b1;
                w_grant_id  = w_idx;
            end
        end
        if (!i_en) begin
            w_grant_any = 1'b0;
        end
        if (w_grant_any) begin
            w_grant[w_grant_id] = 1'b1;
        end
    end

    assign o_req_ready = w_grant;

    // ------------------------------------------------------------------
    // Issue stage. A grant always lands on a valid requester, so a grant
    // is also the handshake.
    // ------------------------------------------------------------------
    logic            r_mul_start;
    logic [31:0]     r_mul_in1;
    logic [31:0]     r_mul_in2;
    logic [IDW-1:0]  r_issue_id;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant <= IDW'(NREQ - 1);
            r_mul_start  <= 1'b0;
            r_mul_in1    <= '0;
            r_mul_in2    <= '0;
            r_issue_id   <= '0;
        end else begin
            r_mul_start <= w_grant_any;
            if (w_grant_any) begin
                r_last_grant <= w_grant_id;
                r_mul_in1    <= w_op1[w_grant_id];
                r_mul_in2    <= w_op2[w_grant_id];
                r_issue_id   <= w_grant_id;
            end
        end
    end

    assign o_mul_start = r_mul_start;
    assign o_mul_in1   = r_mul_in1;
    assign o_mul_in2   = r_mul_in2;

    // ------------------------------------------------------------------
    // Tag pipeline
    // Stage 0 loads on the edge that ends the start cycle. Stage LAT-1 is
    // therefore valid in the cycle where the multiplier raises done for
    // that operation.
    // ------------------------------------------------------------------
    logic            r_tag_v  [LAT];
    logic [IDW-1:0]  r_tag_id [LAT];
    logic [LAT-1:0]  w_tag_vec;

    generate
        for (genvar gi = 0; gi < LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_tag_v[gi]  <= 1'b0;
                        r_tag_id[gi] <= '0;
                    end else begin
                        r_tag_v[gi]  <= r_mul_start;
                        r_tag_id[gi] <= r_issue_id;
                    end
                end
            end else begin : g_body
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_tag_v[gi]  <= 1'b0;
                        r_tag_id[gi] <= '0;
                    end else begin
                        r_tag_v[gi]  <= r_tag_v[gi-1];
                        r_tag_id[gi] <= r_tag_id[gi-1];
                    end
                end
            end
            assign w_tag_vec[gi] = r_tag_v[gi];
        end
    endgenerate

    assign o_busy = r_mul_start | (|w_tag_vec);

    // ------------------------------------------------------------------
    // Result capture and protocol check
    // A done with no matching tag is only reported through o_err. It never
    // produces a result strobe.
    // ------------------------------------------------------------------
    logic            w_done_ok;
    logic            w_mismatch;
    logic [NREQ-1:0] w_res_onehot;

    assign w_done_ok  = i_mul_done & r_tag_v[LAT-1];
    assign w_mismatch = i_mul_done ^ r_tag_v[LAT-1];

    always_comb begin
        w_res_onehot = '0;
        if (w_done_ok) begin
            w_res_onehot[r_tag_id[LAT-1]] = 1'b1;
        end
    end

    logic [NREQ-1:0] r_res_valid;
    logic [31:0]     r_res_data;
    logic            r_res_inf;
    logic            r_res_zero;
    logic            r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_res_valid <= '0;
            r_res_data  <= '0;
            r_res_inf   <= 1'b0;
            r_res_zero  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_res_valid <= w_res_onehot;
            if (w_done_ok) begin
                r_res_data <= i_mul_result;
                r_res_inf  <= i_mul_inf;
                r_res_zero <= i_mul_zero;
            end
            if (w_mismatch) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;
    assign o_res_inf   = r_res_inf;
    assign o_res_zero  = r_res_zero;
    assign o_err       = r_err;

endmodule
